// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: shift modes, FSM states
// and the per-bit next-value select used by shift_bit_cell.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_LSL = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // LEFT means "take the bit from the MSB-side neighbour" (right shifts),
    // RIGHT means "take the bit from the LSB-side neighbour" (left shift).
    typedef enum logic [1:0] {
        SEL_HOLD  = 2'b00,
        SEL_LOAD  = 2'b01,
        SEL_LEFT  = 2'b10,
        SEL_RIGHT = 2'b11
    } cell_sel_e;

endpackage

// File: rtl/shift_bit_cell.sv
// One storage bit of the universal shift register: 4:1 next-value mux
// (hold / load / left neighbour / right neighbour) feeding a flop with
// synchronous clear.
module shift_bit_cell
    import shift_pkg::*;
(
    input  logic      clk,
    input  logic      clr,
    input  cell_sel_e sel,
    input  logic      ld_bit,
    input  logic      left_bit,
    input  logic      right_bit,
    output logic      q
);

    logic q_q;
    logic q_d;

    // Next-value selection for this bit.
    always_comb begin
        q_d = q_q;
        case (sel)
            SEL_HOLD:  q_d = q_q;
            SEL_LOAD:  q_d = ld_bit;
            SEL_LEFT:  q_d = left_bit;
            SEL_RIGHT: q_d = right_bit;
            default:   q_d = q_q;
        endcase
    end

    // Storage flop with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) q_q <= 1'b0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus a self-timed shift of 'amt'
// positions, one per cycle, in LSR/LSL/ASR/ROR mode with busy/done handshake.
// Optional feature macro: SHIFT_OVF_EN enables the sticky shifted-out-one
// flag on ovf; without it ovf is tied to 0.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int N  = 16,
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          ld,
    input  logic [N-1:0]  din,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] amt,
    input  logic          shen,
    input  logic          sin,
    output logic [N-1:0]  dout,
    output logic          sout,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sout_q, sout_d;
    logic          done_q, done_d;

    cell_sel_e     sel;
    logic          accept;
    logic          shifting;
    logic          out_bit;
    logic          fill_msb;
    logic          fill_lsb;
    logic [N-1:0]  dout_w;
    logic [N-1:0]  left_in;
    logic [N-1:0]  right_in;

    // Datapath control: cell select, end-cell fill bits and the bit leaving the word.
    always_comb begin
        accept   = (state_q == ST_IDLE) && start && !ld;
        shifting = (state_q == ST_SHIFT) && shen;
        out_bit  = (mode_q == MODE_LSL) ? dout_w[N-1] : dout_w[0];
        fill_lsb = sin;
        case (mode_q)
            MODE_ASR: fill_msb = dout_w[N-1];
            MODE_ROR: fill_msb = dout_w[0];
            default:  fill_msb = sin;
        endcase
        sel = SEL_HOLD;
        if ((state_q == ST_IDLE) && ld) begin
            sel = SEL_LOAD;
        end else if (shifting) begin
            sel = (mode_q == MODE_LSL) ? SEL_RIGHT : SEL_LEFT;
        end
    end

    assign left_in  = {fill_msb, dout_w[N-1:1]};
    assign right_in = {dout_w[N-2:0], fill_lsb};

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cell
            shift_bit_cell u_cell (
                .clk       (clk),
                .clr       (clr),
                .sel       (sel),
                .ld_bit    (din[gi]),
                .left_bit  (left_in[gi]),
                .right_bit (right_in[gi]),
                .q         (dout_w[gi])
            );
        end
    endgenerate

    // FSM next state, down-counter, sout capture and done pulse.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mode_d = mode_e'(mode);
                    cnt_d  = (amt > CW'(N)) ? CW'(N) : amt;
                    if (amt == '0) done_d  = 1'b1;
                    else           state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (shen) begin
                    cnt_d  = cnt_q - CW'(1);
                    sout_d = out_bit;
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LSR;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

`ifdef SHIFT_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky flag: cleared by an accepted start, set when a 1 leaves the word (not in ROR).
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (shifting && (mode_q != MODE_ROR) && out_bit) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (clr) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign dout = dout_w;
    assign sout = sout_q;
    assign busy = (state_q == ST_SHIFT);
    assign done = done_q;

endmodule
